and_gate_tester: RTL
====================

# and_gate_tester

Built-in self-test sequencer for the board's two-input AND gate. It drives the gate's A and B inputs through all four input combinations and samples the gate's outAND output after a settle time. Each sample is compared against the expected A & B value, and the block reports per-vector mismatches plus an overall pass/fail. It sits beside the gate in the top level: this block owns the stimulus side and the gate's output is its input.

## Interface
Parameters:
- SETTLE_CYCLES, default 4: clock cycles between applying a vector and sampling outAND. Legal range 1–255; 0 is illegal.

Ports:
- clk, input, 1: single system clock; all logic is on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: level; sampled only in IDLE.
- A, output, 1: stimulus to the gate's A input. Registered.
- B, output, 1: stimulus to the gate's B input. Registered.
- outAND, input, 1: the gate's result. Sampled only in SAMPLE.
- busy, output, 1: high while a run is in progress.
- done, output, 1: one-cycle pulse at the end of a run.
- pass, output, 1: high when the last run had zero mismatches. Held until the next accepted start.
- fail_vec, output, 4: bit k set if vector k mismatched. Held until the next accepted start.
- vec_idx, output, 2: index of the vector currently applied.

## Operation
- Vector k is applied as A = k[1], B = k[0]. Order is k = 0, 1, 2, 3.
- Expected result is 1 for k = 3 only.
- States: IDLE, SETTLE, SAMPLE.
- Settle counter: 8 bits. Vector index: 2 bits.
- IDLE: A = B = 0, busy = 0.
  - On start = 1, the next edge does all of the following: vec_idx ← 0; A, B ← 0, 0; cnt ← SETTLE_CYCLES−1; fail_vec ← 0; pass ← 0; busy ← 1; go to SETTLE.
- SETTLE: if cnt == 0, go to SAMPLE; else cnt decrements. This state lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle): fail_vec[vec_idx] ← (outAND != (A & B)).
  - If vec_idx < 3: vec_idx increments; A and B take the new vector on the same edge; cnt reloads; go to SETTLE.
  - If vec_idx == 3: go to IDLE.
    - done ← 1 and busy ← 0.
    - pass ← 1 when no fail_vec bit is set, including the bit written on this same edge.
    - A, B, vec_idx ← 0.
- done is cleared on the edge after it is asserted.
- start is ignored while busy. Runs are not restartable mid-flight.
- start held high continuously gives back-to-back runs. Each new run is accepted in the IDLE cycle in which done is high.
- Accepting a start clears pass and fail_vec on the same edge.

## Timing
- Reset (rst_n = 0 at an edge): state IDLE; A = B = 0; busy = done = pass = 0; fail_vec = 0; vec_idx = 0; cnt = 0.
- Reset has priority over every other event, including mid-run. A run in progress is abandoned with no done pulse.
- Take the cycle in which start is sampled high in IDLE as cycle 0; let S = SETTLE_CYCLES.
  - Vector k is driven from cycle k(S+1)+1.
  - Vector k is sampled in cycle (k+1)(S+1).
  - done is high in cycle 4(S+1)+1. With S = 4 that is cycle 21; with S = 1 it is cycle 9.
- busy is high from cycle 1 through cycle 4(S+1) inclusive.
- outAND must be stable S cycles after A/B change. The gate is on-chip combinational logic, so S ≥ 1 suffices.
- A/B never glitch: they are driven straight from flops and change only on SAMPLE→SETTLE edges, on the final SAMPLE edge, and on start acceptance.

## Test plan
- Real AND gate connected, S = 4, start pulsed in cycle 0.
  Required: A,B sequence 00, 01, 10, 11, each held 5 cycles; done high in cycle 21 only; pass = 1; fail_vec = 0000.
- outAND stuck at 0.
  Required: fail_vec = 1000, pass = 0, done in cycle 21.
- outAND stuck at 1.
  Required: fail_vec = 0111, pass = 0.
- OR gate substituted for the gate (outAND = A | B).
  Required: fail_vec = 0110, pass = 0.
- Extra start pulses during cycles 3–15 are ignored (timing unchanged).
  Then rst_n = 0 in cycle 10. Required: from the next cycle A = B = busy = done = pass = 0, fail_vec = 0, and no done pulse.
  A fresh start then completes normally with pass = 1.
- S = 1 with start held high.
  Required: done in cycle 9. A second run is accepted in that same cycle, clearing pass, and its done comes 9 cycles later in cycle 18.

Source files
------------

// File: rtl/and_gate_tester_if.sv
// Signal bundle between the AND-gate self-test sequencer and its environment.
// The master side is the sequencer; the slave side is the gate plus the controller that starts runs.
interface and_gate_tester_if;
  logic       start;
  logic       A;
  logic       B;
  logic       outAND;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;
  logic [1:0] vec_idx;

  modport master (
    input  start, outAND,
    output A, B, busy, done, pass, fail_vec, vec_idx
  );

  modport slave (
    output start, outAND,
    input  A, B, busy, done, pass, fail_vec, vec_idx
  );
endinterface

// File: rtl/and_gate_tester.sv
// Built-in self-test sequencer for a two-input AND gate: walks A/B through 00,01,10,11,
// samples outAND after SETTLE_CYCLES and reports per-vector mismatches plus overall pass.
module and_gate_tester #(
  parameter int SETTLE_CYCLES = 4
) (
  input logic            clk,
  input logic            rst_n,
  and_gate_tester_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [1:0] vec_idx;
  logic [1:0] vec_next;
  logic       drive_a;
  logic       drive_b;
  logic       done_r;
  logic       pass_r;
  logic [3:0] fail_vec;
  logic [3:0] fail_next;
  logic       miss;
  logic       busy;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SETTLE;
      SETTLE:  if (cnt == 8'd0) state_next = SAMPLE;
      SAMPLE:  state_next = (vec_idx == 2'd3) ? IDLE : SETTLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    miss      = (bus.outAND != (drive_a & drive_b));
    vec_next  = vec_idx + 2'd1;
    fail_next = fail_vec;
    fail_next[vec_idx] = miss;
  end

  // Datapath follows the FSM; the final pass verdict includes the bit written on the last sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= 8'd0;
      vec_idx  <= 2'd0;
      drive_a  <= 1'b0;
      drive_b  <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
      fail_vec <= 4'd0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            vec_idx  <= 2'd0;
            drive_a  <= 1'b0;
            drive_b  <= 1'b0;
            cnt      <= SETTLE_LOAD;
            fail_vec <= 4'd0;
            pass_r   <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
        end
        SAMPLE: begin
          fail_vec <= fail_next;
          if (vec_idx != 2'd3) begin
            vec_idx <= vec_next;
            drive_a <= vec_next[1];
            drive_b <= vec_next[0];
            cnt     <= SETTLE_LOAD;
          end else begin
            done_r  <= 1'b1;
            pass_r  <= ~|fail_next;
            drive_a <= 1'b0;
            drive_b <= 1'b0;
            vec_idx <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.A        = drive_a;
  assign bus.B        = drive_b;
  assign bus.busy     = busy;
  assign bus.done     = done_r;
  assign bus.pass     = pass_r;
  assign bus.fail_vec = fail_vec;
  assign bus.vec_idx  = vec_idx;

endmodule
